// File: rtl/chroni_cpu_reader_if.sv
// CPU-side bus bundle for chroni_cpu_reader: address, read/write strobes,
// snooped write data and the read response.
interface chroni_cpu_reader_if;
   logic [15:0] cpu_addr;
   logic        cpu_rd_en;
   logic        cpu_wr_en;
   logic [7:0]  cpu_wr_data;
   logic [7:0]  cpu_rd_data;
   logic        cpu_rd_valid;
   logic        cpu_busy;

   modport master (
      output cpu_addr, cpu_rd_en, cpu_wr_en, cpu_wr_data,
      input  cpu_rd_data, cpu_rd_valid, cpu_busy
   );

   modport slave (
      input  cpu_addr, cpu_rd_en, cpu_wr_en, cpu_wr_data,
      output cpu_rd_data, cpu_rd_valid, cpu_busy
   );
endinterface

// File: rtl/chroni_cpu_reader.sv
// CPU read responder for the chroni register window (0x9000-0x900F) and VRAM window (0xA000-0xDFFF).
// Palette readback (index/low/high sequencing) is built only when CHRONI_PAL_READBACK_EN is defined.
module chroni_cpu_reader #(
   parameter int VRAM_LATENCY = 2,
   parameter int PAL_LATENCY  = 2
) (
   input  logic                      sys_clk,
   input  logic                      reset_n,
   chroni_cpu_reader_if.slave        cpu,
   input  logic [2:0]                vram_page,
   output logic                      vram_rd_en,
   output logic [16:0]               vram_rd_addr,
   input  logic [7:0]                vram_rd_data,
   output logic [7:0]                pal_rd_addr,
   input  logic [15:0]               pal_rd_data,
   input  logic [1:0]                vga_mode,
   input  logic                      in_vblank,
   input  logic [9:0]                scanline
);

   typedef enum logic [1:0] {IDLE, VRAM_WAIT, PAL_WAIT, RESP} state_t;

   state_t     state, next_state;
   logic [7:0] wait_cnt;
   logic [7:0] rd_data;
   logic [7:0] reg_byte;
   logic [7:0] idx_byte;
   logic [7:0] hi_byte;
   logic [1:0] scan_hi;
   logic [3:0] offset;
   logic       reg_cs, vram_cs, accept, vram_done, pal_done, pal_lo_read;

   assign reg_cs    = (cpu.cpu_addr[15:4] == 12'h900);
   assign vram_cs   = (cpu.cpu_addr[15:13] == 3'b101) || (cpu.cpu_addr[15:13] == 3'b110);
   assign offset    = cpu.cpu_addr[3:0];
   // A simultaneous write wins: the read in that cycle is dropped.
   assign accept    = (state == IDLE) && cpu.cpu_rd_en && !cpu.cpu_wr_en;
   assign vram_done = (state == VRAM_WAIT) && (wait_cnt == 8'(VRAM_LATENCY));
   assign pal_done  = (state == PAL_WAIT) && (wait_cnt == 8'(PAL_LATENCY));

   assign cpu.cpu_rd_data  = rd_data;
   assign cpu.cpu_rd_valid = (state == RESP);
   assign cpu.cpu_busy     = (state == VRAM_WAIT) || (state == PAL_WAIT);

   always_ff @(posedge sys_clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (vram_cs)          next_state = VRAM_WAIT;
               else if (pal_lo_read) next_state = PAL_WAIT;
               else                  next_state = RESP;
            end
         end
         VRAM_WAIT: if (vram_done) next_state = RESP;
         PAL_WAIT:  if (pal_done)  next_state = RESP;
         RESP:      next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   always_comb begin
      reg_byte = 8'hFF;
      if (reg_cs) begin
         case (offset)
            4'd0:    reg_byte = {in_vblank, 5'b0, vga_mode};
            4'd1:    reg_byte = scanline[7:0];
            4'd2:    reg_byte = {6'b0, scan_hi};
            4'd4:    reg_byte = idx_byte;
            4'd5:    reg_byte = hi_byte;
            4'd6:    reg_byte = {5'b0, vram_page};
            default: reg_byte = 8'h00;
         endcase
      end
   end

   // The wait counter restarts on every accept, so it reads 0 in the first wait cycle.
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         rd_data      <= 8'h00;
         vram_rd_en   <= 1'b0;
         vram_rd_addr <= 17'd0;
         scan_hi      <= 2'b00;
         wait_cnt     <= 8'd0;
      end else begin
         vram_rd_en <= 1'b0;
         wait_cnt   <= wait_cnt + 8'd1;
         if (accept) begin
            wait_cnt <= 8'd0;
            if (vram_cs) begin
               vram_rd_en   <= 1'b1;
               vram_rd_addr <= {vram_page, ~cpu.cpu_addr[13], cpu.cpu_addr[12:0]};
            end else if (!pal_lo_read) begin
               rd_data <= reg_byte;
            end
            if (reg_cs && offset == 4'd1) scan_hi <= scanline[9:8];
         end
         if (vram_done) rd_data <= vram_rd_data;
         if (pal_done)  rd_data <= pal_rd_data[7:0];
      end
   end

`ifdef CHRONI_PAL_READBACK_EN
   logic [7:0] pal_idx;
   logic [7:0] pal_hi;
   logic       phase_hi, wr_pending, wr_idx, pal_hi_read;

   assign wr_idx      = cpu.cpu_wr_en && reg_cs && (offset == 4'd4);
   assign pal_lo_read = reg_cs && (offset == 4'd5) && !phase_hi;
   assign pal_hi_read = reg_cs && (offset == 4'd5) && phase_hi;
   assign idx_byte    = pal_idx;
   assign hi_byte     = phase_hi ? pal_hi : 8'h00;

   // An index write during PAL_WAIT lets the fetch finish, but the phase must end up LO.
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         pal_idx     <= 8'd0;
         pal_hi      <= 8'd0;
         phase_hi    <= 1'b0;
         wr_pending  <= 1'b0;
         pal_rd_addr <= 8'd0;
      end else begin
         if (accept && pal_lo_read) begin
            pal_rd_addr <= pal_idx;
            wr_pending  <= 1'b0;
         end
         if (accept && pal_hi_read) begin
            pal_idx  <= pal_idx + 8'd1;
            phase_hi <= 1'b0;
         end
         if (pal_done) begin
            pal_hi   <= pal_rd_data[15:8];
            phase_hi <= !wr_pending;
         end
         if (wr_idx) begin
            pal_idx    <= cpu.cpu_wr_data;
            phase_hi   <= 1'b0;
            wr_pending <= (state == PAL_WAIT);
         end
      end
   end
`else
   logic unused_pal;

   assign unused_pal  = ^{pal_rd_data[15:8], cpu.cpu_wr_data};
   assign pal_lo_read = 1'b0;
   assign idx_byte    = 8'h00;
   assign hi_byte     = 8'h00;
   assign pal_rd_addr = 8'd0;
`endif

endmodule

// File: tb/tb_chroni_cpu_reader.sv
// Bench for chroni_cpu_reader: fixed vector table, hand-written corner sequences,
// then random traffic checked against an address-level reference model.
module tb_chroni_cpu_reader;
   localparam int VL = 2;
   localparam int PL = 2;

   logic        sys_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  vram_page;
   logic        vram_rd_en;
   logic [16:0] vram_rd_addr;
   logic [7:0]  vram_rd_data;
   logic [7:0]  pal_rd_addr;
   logic [15:0] pal_rd_data;
   logic [1:0]  vga_mode;
   logic        in_vblank;
   logic [9:0]  scanline;

   always #5 sys_clk = ~sys_clk;

   chroni_cpu_reader_if bus();

   chroni_cpu_reader #(.VRAM_LATENCY(VL), .PAL_LATENCY(PL)) dut (
      .sys_clk(sys_clk), .reset_n(reset_n), .cpu(bus),
      .vram_page(vram_page), .vram_rd_en(vram_rd_en), .vram_rd_addr(vram_rd_addr),
      .vram_rd_data(vram_rd_data), .pal_rd_addr(pal_rd_addr), .pal_rd_data(pal_rd_data),
      .vga_mode(vga_mode), .in_vblank(in_vblank), .scanline(scanline)
   );

   // Memory models: data appears two cycles after the address is presented.
   logic [15:0] pal_mem [256];
   logic [7:0]  vram_d1;
   logic [15:0] pal_d1;

   function automatic logic [7:0] vram_byte(input logic [16:0] a);
      return a[7:0] ^ {a[16:14], a[12:8]} ^ {7'd0, a[13]} ^ 8'h5A;
   endfunction

   always @(posedge sys_clk) begin
      vram_d1      <= vram_byte(vram_rd_addr);
      vram_rd_data <= vram_d1;
      pal_d1       <= pal_mem[pal_rd_addr];
      pal_rd_data  <= pal_d1;
   end

   int n_vec  = 0;
   int n_fail = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference model state
   logic [7:0] m_idx;
   logic [7:0] m_hi;
   logic       m_phase_hi;
   logic [1:0] m_scan_hi;

   task automatic model_reset();
      m_idx = 8'd0; m_hi = 8'd0; m_phase_hi = 1'b0; m_scan_hi = 2'd0;
   endtask

   function automatic logic [16:0] model_vaddr(input logic [15:0] a, input logic [2:0] page);
      int v;
      v = int'(page) * 16384 + int'(a) - 32'hA000;
      return v[16:0];
   endfunction

   task automatic model_write(input logic [15:0] a, input logic [7:0] d);
`ifdef CHRONI_PAL_READBACK_EN
      if (a[15:4] == 12'h900 && a[3:0] == 4'd4) begin
         m_idx = d;
         m_phase_hi = 1'b0;
      end
`endif
   endtask

   task automatic model_read(input logic [15:0] a, output logic [7:0] d, output int lat);
      lat = 1;
      d = 8'hFF;
      if (a >= 16'hA000 && a <= 16'hDFFF) begin
         d = vram_byte(model_vaddr(a, vram_page));
         lat = 2 + VL;
      end else if (a >= 16'h9000 && a <= 16'h900F) begin
         case (a[3:0])
            4'd0: d = {in_vblank, 5'b0, vga_mode};
            4'd1: begin d = scanline[7:0]; m_scan_hi = scanline[9:8]; end
            4'd2: d = {6'b0, m_scan_hi};
            4'd6: d = {5'b0, vram_page};
`ifdef CHRONI_PAL_READBACK_EN
            4'd4: d = m_idx;
            4'd5: begin
               if (!m_phase_hi) begin
                  d = pal_mem[m_idx][7:0];
                  m_hi = pal_mem[m_idx][15:8];
                  m_phase_hi = 1'b1;
                  lat = 2 + PL;
               end else begin
                  d = m_hi;
                  m_idx = m_idx + 8'd1;
                  m_phase_hi = 1'b0;
               end
            end
`endif
            default: d = 8'h00;
         endcase
      end
   endtask

   // One bus operation; for reads, measures latency from the accepting edge.
   task automatic applyStimulus(input logic is_wr, input logic [15:0] a, input logic [7:0] wd,
                                output logic [7:0] data, output int lat, output logic [16:0] va,
                                output logic ven_ok, output logic busy_ok);
      int n;
      logic ven1, ven2;
      @(negedge sys_clk);
      bus.cpu_addr = a;
      bus.cpu_wr_data = wd;
      if (is_wr) bus.cpu_wr_en = 1'b1;
      else       bus.cpu_rd_en = 1'b1;
      @(negedge sys_clk);
      bus.cpu_wr_en = 1'b0;
      bus.cpu_rd_en = 1'b0;
      data = 8'h00; lat = 0; va = 17'd0; ven_ok = 1'b0; busy_ok = 1'b1;
      if (!is_wr) begin
         n = 1; va = vram_rd_addr; ven1 = vram_rd_en; ven2 = 1'b0;
         while (bus.cpu_rd_valid !== 1'b1 && n < 20) begin
            if (bus.cpu_busy !== 1'b1) busy_ok = 1'b0;
            @(negedge sys_clk);
            n++;
            if (n == 2) ven2 = vram_rd_en;
         end
         if (bus.cpu_busy !== 1'b0) busy_ok = 1'b0;
         lat = (bus.cpu_rd_valid === 1'b1) ? n : 99;
         data = bus.cpu_rd_data;
         ven_ok = ven1 && !ven2;
      end
   endtask

   task automatic doWrite(input logic [15:0] a, input logic [7:0] d);
      logic [7:0] dd; int l; logic [16:0] va; logic vok, bok;
      applyStimulus(1'b1, a, d, dd, l, va, vok, bok);
      model_write(a, d);
   endtask

   task automatic checkRead(input logic [15:0] a);
      logic [7:0] ed, d; int el, l; logic [16:0] va, eva; logic vok, bok, isv;
      isv = (a >= 16'hA000 && a <= 16'hDFFF);
      eva = model_vaddr(a, vram_page);
      model_read(a, ed, el);
      applyStimulus(1'b0, a, 8'h00, d, l, va, vok, bok);
      checkOutput($sformatf("rd_%04h_data", a), d, ed);
      checkOutput($sformatf("rd_%04h_latency", a), l, el);
      checkOutput($sformatf("rd_%04h_busy", a), bok, 1);
      if (isv) begin
         checkOutput($sformatf("rd_%04h_vaddr", a), va, eva);
         checkOutput($sformatf("rd_%04h_ven_pulse", a), vok, 1);
      end
   endtask

   typedef struct {
      logic        is_wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [1:0]  mode;
      logic        vb;
      logic [9:0]  scan;
      logic [2:0]  page;
      logic [7:0]  exp_data;
      int          exp_lat;
      logic        chk_v;
      logic [16:0] exp_vaddr;
   } vec_t;

   vec_t vecs[$];
   vec_t v;

   initial begin
      logic [7:0] p0, p1, p2, p3, pidx, md, d, got;
      int plat, ml, l, pulses, n;
      logic [16:0] va;
      logic vok, bok;

      bus.cpu_addr = 16'h0; bus.cpu_rd_en = 1'b0; bus.cpu_wr_en = 1'b0; bus.cpu_wr_data = 8'h0;
      vram_page = 3'd0; vga_mode = 2'd0; in_vblank = 1'b0; scanline = 10'd0;
      for (int i = 0; i < 256; i++) pal_mem[i] = 16'($urandom);
      pal_mem[255] = 16'h1234;
      pal_mem[0]   = 16'hBEEF;
      model_reset();

      reset_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      checkOutput("reset_valid", bus.cpu_rd_valid, 0);
      checkOutput("reset_busy", bus.cpu_busy, 0);
      checkOutput("reset_rd_data", bus.cpu_rd_data, 0);
      checkOutput("reset_vram_en", vram_rd_en, 0);
      checkOutput("reset_vram_addr", vram_rd_addr, 0);
      checkOutput("reset_pal_addr", pal_rd_addr, 0);
      reset_n = 1'b1;

`ifdef CHRONI_PAL_READBACK_EN
      p0 = 8'h34; p1 = 8'h12; p2 = 8'hEF; p3 = 8'hBE; pidx = 8'h01; plat = 2 + PL;
`else
      p0 = 8'h00; p1 = 8'h00; p2 = 8'h00; p3 = 8'h00; pidx = 8'h00; plat = 1;
`endif
      //               wr    addr      wd     mode  vb    scan      pg    exp                          lat     chkv  vaddr
      vecs.push_back('{1'b0, 16'h9000, 8'h00, 2'd2, 1'b1, 10'h000,  3'd1, 8'h82,                       1,      1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'hA005, 8'h00, 2'd2, 1'b1, 10'h000,  3'd1, vram_byte(17'h04005),        2 + VL, 1'b1, 17'h04005});
      vecs.push_back('{1'b0, 16'hC005, 8'h00, 2'd2, 1'b1, 10'h000,  3'd1, vram_byte(17'h06005),        2 + VL, 1'b1, 17'h06005});
      vecs.push_back('{1'b0, 16'hDFFF, 8'h00, 2'd0, 1'b0, 10'h000,  3'd7, vram_byte(17'h1FFFF),        2 + VL, 1'b1, 17'h1FFFF});
      vecs.push_back('{1'b1, 16'h9004, 8'hFF, 2'd0, 1'b0, 10'h000,  3'd1, 8'h00,                       0,      1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'h9005, 8'h00, 2'd0, 1'b0, 10'h000,  3'd1, p0,                          plat,   1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'h9005, 8'h00, 2'd0, 1'b0, 10'h000,  3'd1, p1,                          1,      1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'h9005, 8'h00, 2'd0, 1'b0, 10'h000,  3'd1, p2,                          plat,   1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'h9005, 8'h00, 2'd0, 1'b0, 10'h000,  3'd1, p3,                          1,      1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'h9004, 8'h00, 2'd0, 1'b0, 10'h000,  3'd1, pidx,                        1,      1'b0, 17'h0});
      vecs.push_back('{1'b1, 16'h9005, 8'h77, 2'd0, 1'b0, 10'h000,  3'd1, 8'h00,                       0,      1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'h9004, 8'h00, 2'd0, 1'b0, 10'h000,  3'd1, pidx,                        1,      1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'h9001, 8'h00, 2'd0, 1'b0, 10'h1F3,  3'd1, 8'hF3,                       1,      1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'h9002, 8'h00, 2'd0, 1'b0, 10'h000,  3'd1, 8'h01,                       1,      1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'h8000, 8'h00, 2'd0, 1'b0, 10'h000,  3'd1, 8'hFF,                       1,      1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'hE000, 8'h00, 2'd0, 1'b0, 10'h000,  3'd1, 8'hFF,                       1,      1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'h9FFF, 8'h00, 2'd0, 1'b0, 10'h000,  3'd1, 8'hFF,                       1,      1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'h9006, 8'h00, 2'd0, 1'b0, 10'h000,  3'd5, 8'h05,                       1,      1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'h9003, 8'h00, 2'd3, 1'b1, 10'h3FF,  3'd5, 8'h00,                       1,      1'b0, 17'h0});
      vecs.push_back('{1'b0, 16'h900F, 8'h00, 2'd3, 1'b1, 10'h3FF,  3'd5, 8'h00,                       1,      1'b0, 17'h0});

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         vga_mode = v.mode; in_vblank = v.vb; scanline = v.scan; vram_page = v.page;
         if (v.is_wr) begin
            doWrite(v.addr, v.wdata);
         end else begin
            model_read(v.addr, md, ml);
            applyStimulus(1'b0, v.addr, 8'h00, d, l, va, vok, bok);
            checkOutput($sformatf("vec%0d_data", i), d, v.exp_data);
            checkOutput($sformatf("vec%0d_latency", i), l, v.exp_lat);
            checkOutput($sformatf("vec%0d_busy", i), bok, 1);
            if (v.chk_v) begin
               checkOutput($sformatf("vec%0d_vaddr", i), va, v.exp_vaddr);
               checkOutput($sformatf("vec%0d_ven_pulse", i), vok, 1);
            end
         end
      end

      // A second request while a VRAM read is in flight must be dropped.
      vram_page = 3'd2;
      @(negedge sys_clk); bus.cpu_addr = 16'hB123; bus.cpu_rd_en = 1'b1;
      @(negedge sys_clk); bus.cpu_addr = 16'h9001;
      @(negedge sys_clk); bus.cpu_rd_en = 1'b0;
      pulses = 0; got = 8'h00;
      for (int i = 0; i < 10; i++) begin
         if (bus.cpu_rd_valid === 1'b1) begin pulses++; got = bus.cpu_rd_data; end
         @(negedge sys_clk);
      end
      checkOutput("busy_ignore_pulses", pulses, 1);
      checkOutput("busy_ignore_data", got, vram_byte(model_vaddr(16'hB123, 3'd2)));

      // Simultaneous read and write: only the write takes effect.
      @(negedge sys_clk);
      bus.cpu_addr = 16'h9004; bus.cpu_wr_data = 8'h22; bus.cpu_rd_en = 1'b1; bus.cpu_wr_en = 1'b1;
      @(negedge sys_clk); bus.cpu_rd_en = 1'b0; bus.cpu_wr_en = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.cpu_rd_valid === 1'b1) pulses++;
         @(negedge sys_clk);
      end
      checkOutput("rdwr_collision_pulses", pulses, 0);
      model_write(16'h9004, 8'h22);
      checkRead(16'h9004);

`ifdef CHRONI_PAL_READBACK_EN
      // Index write while a low-byte fetch is pending.
      doWrite(16'h9004, 8'h30);
      @(negedge sys_clk); bus.cpu_addr = 16'h9005; bus.cpu_rd_en = 1'b1;
      @(negedge sys_clk); bus.cpu_rd_en = 1'b0;
      bus.cpu_addr = 16'h9004; bus.cpu_wr_data = 8'h10; bus.cpu_wr_en = 1'b1;
      @(negedge sys_clk); bus.cpu_wr_en = 1'b0;
      n = 2;
      while (bus.cpu_rd_valid !== 1'b1 && n < 20) begin @(negedge sys_clk); n++; end
      checkOutput("palwait_write_latency", n, 2 + PL);
      checkOutput("palwait_write_data", bus.cpu_rd_data, pal_mem[8'h30][7:0]);
      model_write(16'h9004, 8'h10);
      checkRead(16'h9005);
      checkRead(16'h9005);
      checkRead(16'h9004);
`endif

      // Reset in the middle of a VRAM read aborts it silently.
      @(negedge sys_clk); bus.cpu_addr = 16'hA123; bus.cpu_rd_en = 1'b1;
      @(negedge sys_clk); bus.cpu_rd_en = 1'b0;
      @(negedge sys_clk); reset_n = 1'b0;
      @(negedge sys_clk);
      checkOutput("midreset_valid", bus.cpu_rd_valid, 0);
      checkOutput("midreset_busy", bus.cpu_busy, 0);
      checkOutput("midreset_rd_data", bus.cpu_rd_data, 0);
      checkOutput("midreset_vram_en", vram_rd_en, 0);
      checkOutput("midreset_vram_addr", vram_rd_addr, 0);
      checkOutput("midreset_pal_addr", pal_rd_addr, 0);
      reset_n = 1'b1;
      model_reset();
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge sys_clk);
         if (bus.cpu_rd_valid === 1'b1) pulses++;
      end
      checkOutput("midreset_pulses", pulses, 0);
      checkRead(16'h9002);
      checkRead(16'h9004);

      // Random traffic against the reference model.
      for (int i = 0; i < 80; i++) begin
         vga_mode  = 2'($urandom_range(0, 3));
         in_vblank = 1'($urandom_range(0, 1));
         scanline  = 10'($urandom_range(0, 1023));
         vram_page = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 9))
            0:       doWrite(16'h9004, 8'($urandom));
            1:       doWrite(16'($urandom), 8'($urandom));
            2, 3:    checkRead(16'h9005);
            4:       checkRead(16'h9000 + 16'($urandom_range(0, 15)));
            5, 6:    checkRead(16'($urandom_range(16'hA000, 16'hDFFF)));
            7:       checkRead(16'($urandom));
            8:       checkRead(16'h9001);
            default: checkRead(16'h9002);
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
